// File: rtl/alu_pkg.sv
// Shared types for the ALU select sweep sequencer.
// Op codes, op count and sequencer state encoding.
package alu_pkg;

    localparam int NUM_OPS = 7;

    localparam logic [2:0] OP_0 = 3'd0;
    localparam logic [2:0] OP_1 = 3'd1;
    localparam logic [2:0] OP_2 = 3'd2;
    localparam logic [2:0] OP_3 = 3'd3;
    localparam logic [2:0] OP_4 = 3'd4;
    localparam logic [2:0] OP_5 = 3'd5;
    localparam logic [2:0] OP_6 = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_SETTLE = 3'd2,
        S_OUTPUT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/alu_op_pick.sv
// Lowest-set-bit priority encoder over the pending op mask.
// Returns the op code to issue next and whether any op remains.
module alu_op_pick
    import alu_pkg::*;
(
    input  logic [NUM_OPS-1:0] mask,
    output logic [2:0]         code,
    output logic               any
);

    // scan high to low so the lowest set bit wins
    always_comb begin
        code = OP_0;
        any  = |mask;
        for (int k = NUM_OPS - 1; k >= 0; k--) begin
            if (mask[k]) code = 3'(k);
        end
    end

endmodule

// File: rtl/alu_sweep_sequencer.sv
// Drives selected ALU op codes in ascending order and
// streams each captured result out with its op code.
module alu_sweep_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [6:0]       op_mask,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_s0,
    output logic             alu_s1,
    output logic             alu_s2,
    input  logic [WIDTH-1:0] alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [2:0]       res_op,
    output logic             busy,
    output logic             done
);

    localparam int CW = (SETTLE_CYCLES < 2) ? 1
                      : $clog2(SETTLE_CYCLES + 1);

    state_t             state;
    state_t             nxt;
    logic [NUM_OPS-1:0] pend;
    logic [NUM_OPS-1:0] onehot;
    logic [2:0]         sel;
    logic [2:0]         pick_code;
    logic               pick_any;
    logic [CW-1:0]      cnt;
    logic               hs;
    logic               more;
    logic               last;

    alu_op_pick u_pick (
        .mask (pend),
        .code (pick_code),
        .any  (pick_any)
    );

    assign hs     = res_valid && res_ready;
    assign onehot = {{(NUM_OPS-1){1'b0}}, 1'b1} << sel;
    assign more   = |(pend & ~onehot);
    assign last   = (cnt == CW'(1));

    assign {alu_s0, alu_s1, alu_s2} = sel;
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // next-state decode
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    nxt = (op_mask != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE:  nxt = pick_any ? S_SETTLE : S_DONE;
            S_SETTLE: if (last) nxt = S_OUTPUT;
            S_OUTPUT: begin
                if (hs) nxt = more ? S_ISSUE : S_DONE;
            end
            S_DONE:   nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // operands, pending mask, selects, counter, result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            pend      <= '0;
            sel       <= '0;
            cnt       <= '0;
            res_op    <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && op_mask != '0) begin
                        alu_a <= a_in;
                        alu_b <= b_in;
                        pend  <= op_mask;
                    end
                end
                S_ISSUE: begin
                    sel    <= pick_code;
                    res_op <= pick_code;
                    cnt    <= CW'(SETTLE_CYCLES);
                end
                S_SETTLE: begin
                    if (last) begin
                        res_data  <= alu_result;
                        res_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_OUTPUT: begin
                    if (hs) begin
                        pend      <= pend & ~onehot;
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
